// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB packet types and functional-unit indices
package cdb_arbiter_pkg;

  localparam int ROB_LEN   = 32;
  localparam int CDB_XLEN  = 32;
  localparam int CDB_TAG_W = $clog2(ROB_LEN);

  localparam int FU_ALU  = 0;
  localparam int FU_MULT = 1;
  localparam int FU_LOAD = 2;
  localparam int FU_BR   = 3;
  localparam int NUM_FU  = 4;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic                 valid;
  } REG_TAG;

  // Broadcast consumed by ROB completion and RS/map-table wakeup
  typedef struct packed {
    REG_TAG              reg_tag;
    logic [CDB_XLEN-1:0] reg_value;
    logic                take_branch;
    logic                no_output;
  } CDB_PACKET;

  // Contents of one per-unit hold buffer
  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
    logic                 has_dest;
    logic                 take_branch;
  } CDB_REQ_PACKET;

  function automatic CDB_PACKET cdb_bubble();
    CDB_PACKET p;
    p           = '0;
    p.no_output = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin one-hot grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Scan from the pointer with wrap-around; the first requester wins
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - hold buffers plus round-robin arbitration onto the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = CDB_XLEN,
  parameter int TAG_W   = CDB_TAG_W,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           squash,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_value,
  input  logic [NUM_REQ-1:0]             req_has_dest,
  input  logic [NUM_REQ-1:0]             req_take_branch,
  output logic [NUM_REQ-1:0]             req_ready,
  output CDB_PACKET                      cdb_packet_out,
  output logic [NUM_REQ-1:0]             grant_oh
);

  logic [NUM_REQ-1:0] r_occ;
  CDB_REQ_PACKET      r_buf [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_accept;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_next_ptr;
  CDB_REQ_PACKET      w_win_buf;

  // Stall, squash and reset all suppress arbitration entirely
  assign w_arb_req = (reset || stall || squash) ? '0 : r_occ;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req    (w_arb_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant)
  );

  assign grant_oh  = w_grant;
  // A granted buffer frees up in the same cycle, so it can be refilled without a bubble
  assign req_ready = (reset || squash) ? '0 : (~r_occ | w_grant);
  assign w_accept  = req_valid & req_ready;

  // Encode the one-hot grant and compute the pointer just past the winner
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_winner = PTR_W'(i);
      end
    end
    w_next_ptr = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    w_win_buf  = r_buf[w_winner];
  end

  // Hold buffers: load on accept, release on grant, flush on squash
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_occ <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_occ[i]               <= 1'b1;
          r_buf[i].tag           <= req_tag[i];
          r_buf[i].value         <= req_value[i];
          r_buf[i].has_dest      <= req_has_dest[i];
          r_buf[i].take_branch   <= req_take_branch[i];
        end else if (w_grant[i]) begin
          r_occ[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast and round-robin pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      cdb_packet_out <= cdb_bubble();
    end else if (|w_grant) begin
      r_rr_ptr                     <= w_next_ptr;
      cdb_packet_out.reg_tag.tag   <= w_win_buf.tag;
      cdb_packet_out.reg_tag.valid <= w_win_buf.has_dest;
      cdb_packet_out.reg_value     <= w_win_buf.value;
      cdb_packet_out.take_branch   <= w_win_buf.take_branch;
      cdb_packet_out.no_output     <= 1'b0;
    end else begin
      cdb_packet_out <= cdb_bubble();
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single Common Data Bus among the functional units: ALU, multiplier, load unit and branch unit. Each requester gets a one-entry hold buffer. A round-robin arbiter grants one buffer per cycle, and the winner is registered onto the CDB. The CDB output feeds the ROB completion logic and the RS/map-table wakeup. The block honours pipeline `stall` and ROB-driven `squash` so that no completion is lost or broadcast twice.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting functional units; must be at least 2.
- `XLEN`, default 32: data width.
- `TAG_W`, default `$clog2(ROB_LEN)`: ROB tag width.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: reset; synchronous, active-high.
- `stall`  in  1: pipeline stall; no grant is made while it is high.
- `squash`  in  1: mispredict flush from the ROB.
- `req_valid`  in  `NUM_REQ`: per-unit completion request.
- `req_tag`  in  `NUM_REQ` x `TAG_W`: ROB entry of the completing instruction.
- `req_value`  in  `NUM_REQ` x `XLEN`: result value.
- `req_has_dest`  in  `NUM_REQ`: result writes a register; drives `reg_tag.valid`.
- `req_take_branch`  in  `NUM_REQ`: branch resolved taken.
- `req_ready`  out  `NUM_REQ`: the unit's request is accepted this cycle.
- `cdb_packet_out`  out  `CDB_PACKET`: registered broadcast with fields `reg_tag.tag`, `reg_tag.valid`, `reg_value`, `take_branch`, `no_output`.
- `grant_oh`  out  `NUM_REQ`: one-hot, combinational; the buffer granted this cycle (debug/verification).

## Operation
- Hold buffer i holds `{occ, tag, value, has_dest, take_branch}`.
- `req_ready[i] = !squash && (!occ[i] || grant_oh[i])`.
- Accept rule: `req_valid[i] && req_ready[i]` writes buffer i at the clock edge.
  - If buffer i is granted in the same cycle, the new request replaces it; there is no bubble.
  - Otherwise a full buffer holds its contents; the unit must keep `req_valid` and its data stable until accepted.
- Arbitration, combinational:
  - Scan the occupied buffers starting at `rr_ptr`, wrapping modulo `NUM_REQ`.
  - The first occupied buffer wins.
  - There is no winner if all buffers are empty, or if `stall` or `squash` is high.
- On a grant:
  - The output register loads the winner's fields with `no_output=0`.
  - `occ[winner]` clears, unless it is refilled in the same cycle.
  - `rr_ptr <= (winner+1) mod NUM_REQ`.
- With no grant, the output register loads a bubble: `no_output=1`, `tag=0`, `value=0`, `reg_tag.valid=0`, `take_branch=0`. `rr_ptr` is unchanged.
- `stall`: buffers hold and a bubble is broadcast. A held entry is broadcast exactly once, after the stall ends.
- `squash`:
  - All `occ` bits clear at the edge.
  - Inputs in that cycle are dropped.
  - The output register loads a bubble.
  - `rr_ptr` is unchanged.
  - `squash` takes precedence over `stall`.
- Fairness: a continuously occupied buffer is granted within `NUM_REQ` non-stalled cycles.

## Timing
- Reset values:
  - All `occ`=0, `rr_ptr`=0.
  - `cdb_packet_out`: `no_output=1`, all other fields 0.
  - `req_ready` is all 1 in the first cycle after reset; it is all 0 while `reset` is high.
- Latency:
  - A request accepted at edge E0 is broadcast at the earliest after edge E1, i.e. visible for one cycle starting after E1.
  - Minimum accept-to-broadcast latency is 1 cycle after acceptance.
- Throughput: one broadcast per non-stalled cycle.
- Each broadcast is held for exactly one cycle; the next edge overwrites it with a grant or a bubble.
- Reset mid-operation discards all pending buffers; nothing is broadcast afterwards.

## Structure
- Shared package holds:
  - `CDB_PACKET` (already shared with the ROB).
  - A new `CDB_REQ_PACKET`: `{tag, value, has_dest, take_branch}`.
  - `FU_ALU`/`FU_MULT`/`FU_LOAD`/`FU_BR` index constants, plus `NUM_FU`.
- Sub-module `rr_arbiter` (`NUM_REQ` parameter):
  - Inputs: request vector and `rr_ptr`.
  - Output: one-hot grant.
  - Purely combinational; `rr_ptr` is owned by `cdb_arbiter`.

## Test plan
- Reset, then ALU request tag=3, value=0x11, has_dest=1 -> one cycle after acceptance, CDB shows tag=3, value=0x11, reg_tag.valid=1, no_output=0; then a bubble.
- All 4 units request in the same cycle and hold valid with `rr_ptr`=0 -> broadcasts in order 0,1,2,3 on consecutive cycles; `req_ready` deasserts for the waiting units until each is granted.
- Unit 1 streams a new request every cycle while unit 2 holds one -> units 1 and 2 alternate; unit 2 waits at most 1 cycle.
- Buffer occupied and `stall` held 3 cycles -> 3 bubbles, then a single broadcast of the entry with no duplicate.
- Two buffers occupied plus a new request from unit 0 on a `squash` cycle -> all dropped; `no_output=1` for 2 cycles; `rr_ptr` unchanged.
- Branch unit request with take_branch=1, has_dest=0 -> CDB shows take_branch=1, reg_tag.valid=0.
